alu_sched: RTL and testbench

- Shares one 64-bit alu instance among NUM_REQ requesters.
- Round-robin arbitration picks one request at a time.
- Each accepted op holds its operands stable on the alu for an op-dependent number of cycles, modelling multi-cycle MUL/DIV timing.
- Returns the registered result, the four flags and the requester ID over a valid/ready response channel.
- Sits between the issue logic of the execution cores and the single shared alu datapath.

---
 rtl/alu_sched_pkg.sv | 40 ++++
 rtl/alu.sv | 47 ++++
 rtl/alu_rr_pick.sv | 31 +++
 rtl/alu_sched.sv | 154 +++++++++++++++
 tb/tb_alu_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and helpers for the alu scheduler.
// Opcodes, flag bit positions, FSM states, per-op hold latency.
package alu_sched_pkg;

    localparam int W = 64;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3
    } op_t;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Hold cycles on the alu for an opcode; illegal ops never
    // reach EXEC so their value is irrelevant.
    function automatic int lat_of(
        input logic [2:0] op,
        input int         lat_as,
        input int         lat_mul,
        input int         lat_div
    );
        case (op)
            3'd2:    return lat_mul;
            3'd3:    return lat_div;
            default: return lat_as;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// alu: 64-bit ADD/SUB/MUL/DIV datapath, flags {V,N,C,Z}.
// In: op, a, b. Out: c, flags. SUB carry is the unsigned borrow.
module alu
    import alu_sched_pkg::*;
(
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [3:0]   flags
);

    logic [W:0] sum;
    logic [W:0] dif;
    logic       cy;
    logic       ov;

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        c  = '0;
        cy = 1'b0;
        ov = 1'b0;
        case (op)
            OP_ADD: begin
                c  = sum[W-1:0];
                cy = sum[W];
                ov = (a[W-1] == b[W-1]) && (c[W-1] != a[W-1]);
            end
            OP_SUB: begin
                c  = dif[W-1:0];
                cy = dif[W];
                ov = (a[W-1] != b[W-1]) && (c[W-1] != a[W-1]);
            end
            OP_MUL: c = a * b;
            OP_DIV: c = (b == '0) ? '1 : a / b;
            default: c = '0;
        endcase
        flags        = '0;
        flags[FLG_Z] = (c == '0);
        flags[FLG_C] = cy;
        flags[FLG_N] = c[W-1];
        flags[FLG_V] = ov;
    end

endmodule

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational round-robin one-hot picker.
// In: req (valid vector), ptr (highest priority). Out: grant, grant_id.
module alu_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one alu among NUM_REQ
// requesters, with multi-cycle hold and a valid/ready response.
// Ports: req_valid/req_ready/req_op/req_a/req_b (packed per requester),
// rsp_valid/rsp_ready/rsp_id/rsp_c/rsp_flags/rsp_err, busy.
// Optional ALU_SCHED_STATS_EN adds stat_ops and stat_stall counters.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDSUB_LAT = 1,
    parameter  int MUL_LAT    = 4,
    parameter  int DIV_LAT    = 16,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*3-1:0] req_op,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [W-1:0]         rsp_c,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err,
    output logic                 busy
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_ops,
    output logic [31:0]          stat_stall
`endif
);

    state_t             state;
    state_t             nxt;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gid;
    logic [IW-1:0]      id_r;
    logic [NUM_REQ-1:0] grant;
    logic [2:0]         op_in;
    logic [2:0]         op_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       alu_c;
    logic [3:0]         alu_f;
    logic [15:0]        cnt;
    logic               acc;
    logic               hs;
    logic               div0;

    alu_rr_pick #(.N(NUM_REQ)) u_pick (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (gid)
    );

    alu u_alu (
        .op    (op_t'(op_r)),
        .a     (a_r),
        .b     (b_r),
        .c     (alu_c),
        .flags (alu_f)
    );

    assign op_in = req_op[int'(gid)*3 +: 3];
    assign acc   = (state == IDLE) && (|req_valid);
    assign hs    = rsp_valid && rsp_ready;
    assign div0  = (op_r == OP_DIV) && (b_r == '0);
    assign rsp_id = id_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (acc) nxt = op_in[2] ? RESP : EXEC;
            EXEC: if (cnt == '0) nxt = RESP;
            RESP: if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) ? grant : '0;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            id_r      <= '0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            rsp_c     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    id_r <= gid;
                    op_r <= op_in;
                    a_r  <= req_a[int'(gid)*W +: W];
                    b_r  <= req_b[int'(gid)*W +: W];
                    cnt  <= 16'(lat_of(op_in, ADDSUB_LAT,
                                       MUL_LAT, DIV_LAT) - 1);
                    if (op_in[2]) begin
                        rsp_c     <= '0;
                        rsp_flags <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        // divide-by-zero overrides whatever the alu shows
                        rsp_c     <= div0 ? '1 : alu_c;
                        rsp_flags <= div0 ? 4'b0000 : alu_f;
                        rsp_err   <= div0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                RESP: if (hs) begin
                    ptr <= (id_r == IW'(NUM_REQ - 1)) ? '0
                                                      : id_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (hs && stat_ops != '1)
                stat_ops <= stat_ops + 32'd1;
            if (rsp_valid && !rsp_ready && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scoreboard bench for alu_sched with a reference
// model; driver pushes expectations, monitor pops on rsp_valid.
module tb_alu_sched;

    localparam int NR = 4;
    localparam int AL = 1;
    localparam int ML = 4;
    localparam int DL = 16;

    typedef struct {
        int          id;
        logic [63:0] c;
        logic [3:0]  f;
        logic        err;
        int          due;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*3-1:0]  req_op;
    logic [NR*64-1:0] req_a;
    logic [NR*64-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [63:0]    rsp_c;
    logic [3:0]     rsp_flags;
    logic           rsp_err;
    logic           busy;
`ifdef ALU_SCHED_STATS_EN
    logic [31:0]    stat_ops;
    logic [31:0]    stat_stall;
`endif

    logic [2:0]     s_op [NR];
    logic [63:0]    s_a  [NR];
    logic [63:0]    s_b  [NR];

    exp_t q[$];
    int   cyc = 0;
    int   hs_count = 0;
    int   st_ops = 0;
    int   st_stall = 0;
    int   stall_req = 0;
    int   stall_used = 0;
    int   mptr = 0;
    int   d_chk = 0;
    int   d_fail = 0;
    int   m_chk = 0;
    int   m_fail = 0;

    alu_sched #(
        .NUM_REQ(NR), .ADDSUB_LAT(AL), .MUL_LAT(ML), .DIV_LAT(DL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .busy      (busy)
`ifdef ALU_SCHED_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_stall(stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < NR; i++) begin
            req_op[3*i +: 3] = s_op[i];
            req_a[64*i +: 64] = s_a[i];
            req_b[64*i +: 64] = s_b[i];
        end
    end

    // Reference model straight from the opcode definitions.
    function automatic exp_t model(input logic [2:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        exp_t e;
        logic [64:0] wu;
        logic signed [64:0] ws;
        logic cf;
        logic vf;
        e.id = 0; e.due = 0; e.err = 1'b0;
        e.c = '0; e.f = '0; cf = 1'b0; vf = 1'b0;
        case (op)
            3'd0: begin
                wu = {1'b0, a} + {1'b0, b};
                ws = $signed({a[63], a}) + $signed({b[63], b});
                e.c = wu[63:0]; cf = wu[64];
                vf = ws[64] != ws[63];
            end
            3'd1: begin
                e.c = a - b; cf = a < b;
                ws = $signed({a[63], a}) - $signed({b[63], b});
                vf = ws[64] != ws[63];
            end
            3'd2: e.c = a * b;
            3'd3: begin
                if (b == 0) begin e.c = '1; e.err = 1'b1; end
                else e.c = a / b;
            end
            default: e.err = 1'b1;
        endcase
        if (!e.err) e.f = {vf, e.c[63], cf, e.c == 0};
        return e;
    endfunction

    function automatic int lat(input logic [2:0] op);
        if (op == 3'd2) return ML;
        if (op == 3'd3) return DL;
        return AL;
    endfunction

    task automatic dchk(input string n, input logic [63:0] act,
                        input logic [63:0] exp);
        d_chk++;
        if (act !== exp) begin
            d_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic mchk(input string n, input logic [63:0] act,
                        input logic [63:0] exp);
        m_chk++;
        if (act !== exp) begin
            m_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Monitor: compares every response cycle against the queue head.
    exp_t cur;
    bit   active = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
            rsp_ready = 1'b0;
            st_ops = 0;
            st_stall = 0;
        end else if (rsp_valid) begin
            if (!active) begin
                if (q.size() == 0) begin
                    mchk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    cur = q[0];
                    active = 1;
                    mchk("rsp_time", 64'(cyc), 64'(cur.due));
                end
            end
            if (active) begin
                mchk("rsp_id", 64'(rsp_id), 64'(cur.id));
                mchk("rsp_c", rsp_c, cur.c);
                mchk("rsp_flags", 64'(rsp_flags), 64'(cur.f));
                mchk("rsp_err", 64'(rsp_err), 64'(cur.err));
                mchk("ready_in_resp", 64'(req_ready), 64'd0);
                mchk("busy_in_resp", 64'(busy), 64'd1);
            end
            if (stall_used < stall_req) begin
                rsp_ready = 1'b0;
                stall_used++;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (rsp_ready) begin
                if (active) begin
                    void'(q.pop_front());
                    active = 0;
                end
                hs_count++;
                st_ops++;
            end else begin
                st_stall++;
            end
        end else begin
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = 1'($urandom_range(0, 1));
            s_op[i] = 3'($urandom_range(0, 7));
            s_a[i] = {$urandom, $urandom};
            s_b[i] = {$urandom, $urandom};
        end
    endtask

    // Issue whatever the requesters present, predict the winner,
    // push the expected response and wait for its handshake.
    task automatic txn();
        int w;
        int prev;
        int n;
        exp_t e;
        logic [NR-1:0] er;
        prev = hs_count;
        #1;
        w = -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (mptr + k) % NR;
            if (w < 0 && req_valid[i]) w = i;
        end
        er = (w < 0) ? '0 : NR'(1) << w;
        dchk("req_ready", 64'(req_ready), 64'(er));
        dchk("busy_idle", 64'(busy), 64'd0);
        if (w < 0) begin
            step();
            return;
        end
        e = model(s_op[w], s_a[w], s_b[w]);
        e.id = w;
        e.due = cyc + 1 + (s_op[w][2] ? 0 : lat(s_op[w]));
        q.push_back(e);
        step();
        scramble();
        n = 0;
        while (hs_count == prev && n < 300) begin
            step();
            n++;
        end
        if (hs_count == prev)
            dchk("rsp_timeout", 64'(hs_count), 64'(prev + 1));
        step();
        mptr = (w + 1) % NR;
    endtask

    task automatic set1(input int i, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b);
        req_valid = '0;
        req_valid[i] = 1'b1;
        s_op[i] = op;
        s_a[i] = a;
        s_b[i] = b;
    endtask

    task automatic chk_zero(input string n);
        dchk({n, "_req_ready"}, 64'(req_ready), 64'd0);
        dchk({n, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        dchk({n, "_rsp_id"}, 64'(rsp_id), 64'd0);
        dchk({n, "_rsp_c"}, rsp_c, 64'd0);
        dchk({n, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
        dchk({n, "_rsp_err"}, 64'(rsp_err), 64'd0);
        dchk({n, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            s_op[i] = '0; s_a[i] = '0; s_b[i] = '0;
        end
        step();
        step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // All valid with ADD: grants rotate 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            req_valid = '1;
            for (int i = 0; i < NR; i++) begin
                s_op[i] = 3'd0;
                s_a[i] = 64'(i * 10);
                s_b[i] = 64'(t);
            end
            txn();
        end

        set1(0, 3'd0, 64'd5, 64'd7);
        txn();
        set1(2, 3'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        txn();
        set1(1, 3'd3, 64'd100, 64'd0);
        txn();
        set1(1, 3'b101, 64'd9, 64'd9);
        txn();
        set1(3, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        txn();
        set1(0, 3'd1, 64'd1, 64'd2);
        txn();

        stall_req += 10;
        set1(3, 3'd1, 64'd4, 64'd4);
        txn();

        // Reset in the middle of a DIV: the op must vanish.
        set1(3, 3'd3, 64'd1000, 64'd7);
        #1;
        dchk("div_grant", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        step();
        step();
        dchk("busy_exec", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        step();
        step();
        rst_n = 1'b1;
        mptr = 0;
        step();
        step();
        req_valid = '1;
        for (int i = 0; i < NR; i++) begin
            s_op[i] = 3'd1;
            s_a[i] = 64'(i + 50);
            s_b[i] = 64'(i);
        end
        txn();

        for (int t = 0; t < 60; t++) begin
            int r;
            for (int i = 0; i < NR; i++) begin
                r = $urandom_range(0, 11);
                s_op[i] = (r < 10) ? 3'(r % 4)
                                   : 3'($urandom_range(4, 7));
                s_a[i] = ($urandom_range(0, 3) == 0)
                       ? 64'($urandom_range(0, 20))
                       : {$urandom, $urandom};
                case ($urandom_range(0, 4))
                    0: s_b[i] = 64'd0;
                    1: s_b[i] = 64'($urandom_range(1, 20));
                    2: s_b[i] = s_a[i];
                    default: s_b[i] = {$urandom, $urandom};
                endcase
                req_valid[i] = ($urandom_range(0, 2) != 0);
            end
            txn();
        end

        req_valid = '0;
        step();
        step();
`ifdef ALU_SCHED_STATS_EN
        dchk("stat_ops", 64'(stat_ops), 64'(st_ops));
        dchk("stat_stall", 64'(stat_stall), 64'(st_stall));
`endif
        dchk("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 d_chk + m_chk, d_fail + m_fail);
        $finish;
    end

endmodule
